// File: rtl/led_cube_stream_pkg.sv
// ---------------------------------------------------------------------------
// led_cube_stream_pkg
// Shared constants and types for the LED cube streaming protocol (mode 3).
// Used by both the transmit framer and the cube-side stream receiver.
//   SYNC_BYTE   : byte sent before the start byte.
//   START_BYTE  : byte that opens a frame's data section.
//   FRAME_BYTES : data bytes per cube frame.
//   FRAME_AW    : address width of one frame buffer.
//   framer_state_e : transmit framer state; names the byte on tx_data.
// ---------------------------------------------------------------------------
package led_cube_stream_pkg;

    localparam logic [7:0]  SYNC_BYTE   = 8'h30;
    localparam logic [7:0]  START_BYTE  = 8'h20;
    localparam int unsigned FRAME_BYTES = 64;
    localparam int unsigned FRAME_AW    = 6;
    localparam int unsigned SYNC_CW     = 4;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_SYNC,
        FR_START,
        FR_DATA,
        FR_TRAILER
    } framer_state_e;

    // A trailer of SYNC_BYTE doubles as the sync prefix of the next frame.
    function automatic logic [7:0] trailer_byte(input logic       cont,
                                                input logic [7:0] end_byte);
        return cont ? SYNC_BYTE : end_byte;
    endfunction

endpackage

// File: rtl/led_cube_frame_pingpong.sv
// ---------------------------------------------------------------------------
// led_cube_frame_pingpong
// Two 64x8 frame buffers. One is the front (read by the serialiser), the
// other the back (written by the producer). A swap pulse exchanges roles.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (select only)
//   wr_en/wr_addr/wr_data : write port, always targets the back buffer
//   swap                : exchange front/back at the next edge
//   rd_addr / rd_data   : combinational read of the front buffer
// ---------------------------------------------------------------------------
module led_cube_frame_pingpong
    import led_cube_stream_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [FRAME_AW-1:0] wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                swap,
    input  logic [FRAME_AW-1:0] rd_addr,
    output logic [7:0]          rd_data
);

    logic [7:0] buf0_q [FRAME_BYTES];
    logic [7:0] buf1_q [FRAME_BYTES];

    // front_sel_q == 0: buf0 is front, buf1 is back.
    logic front_sel_q;
    logic front_sel_d;

    always_comb begin
        front_sel_d = front_sel_q;
        if (swap) begin
            front_sel_d = ~front_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            front_sel_q <= 1'b0;
        end else begin
            front_sel_q <= front_sel_d;
        end
    end

    // Write uses the select of the current cycle, so a write coincident with
    // a swap lands in the buffer that is about to become the front.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel_q) begin
                buf0_q[wr_addr] <= wr_data;
            end else begin
                buf1_q[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = front_sel_q ? buf1_q[rd_addr] : buf0_q[rd_addr];
    end

endmodule

// File: rtl/led_cube_stream_framer.sv
// ---------------------------------------------------------------------------
// led_cube_stream_framer
// Transmit-side framer for the LED cube stream. Holds one 64-byte frame in a
// ping-pong buffer and serialises it as:
//   SYNC_COUNT x 0x30, 0x20, 64 data bytes, trailer
// The trailer is 0x30 when another frame follows back-to-back (the next frame
// then starts directly with 0x20), otherwise END_BYTE.
// Parameters:
//   SYNC_COUNT : sync bytes sent when starting from idle (1..15)
//   END_BYTE   : trailer when no frame follows (never 8'h30)
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   enable         : streaming permitted
//   wr_en/wr_addr/wr_data : back-buffer write port
//   frame_commit   : back buffer holds a complete frame
//   tx_data/tx_valid/tx_ready : registered byte stream with handshake
//   busy           : not idle
//   frame_pending  : committed frame waiting in back buffer
//   frames_sent    : frames whose trailer was accepted (wraps)
// ---------------------------------------------------------------------------
module led_cube_stream_framer
    import led_cube_stream_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = 1,
    parameter logic [7:0]  END_BYTE   = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [FRAME_AW-1:0] wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                frame_commit,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                frame_pending,
    output logic [15:0]         frames_sent
);

    localparam logic [SYNC_CW-1:0]  SYNC_LAST = SYNC_CW'(SYNC_COUNT);
    localparam logic [FRAME_AW-1:0] IDX_LAST  = FRAME_AW'(FRAME_BYTES - 1);

    framer_state_e       state_q, state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                pending_q, pending_d;
    logic [15:0]         frames_q, frames_d;
    logic [FRAME_AW-1:0] idx_q, idx_d;
    logic [SYNC_CW-1:0]  sync_cnt_q, sync_cnt_d;
    logic                cont_q, cont_d;

    logic                hs;
    logic                swap;
    logic [FRAME_AW-1:0] rd_addr;
    logic [7:0]          rd_data;

    led_cube_frame_pingpong u_pingpong (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .swap    (swap),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign hs = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pending_d  = pending_q;
        frames_d   = frames_q;
        idx_d      = idx_q;
        sync_cnt_d = sync_cnt_q;
        cont_d     = cont_q;
        swap       = 1'b0;
        // Prefetch the byte that follows the one currently presented.
        rd_addr    = (state_q == FR_DATA) ? (idx_q + FRAME_AW'(1)) : '0;

        unique case (state_q)
            FR_IDLE: begin
                tx_valid_d = 1'b0;
                if (pending_q && enable) begin
                    swap       = 1'b1;
                    state_d    = FR_SYNC;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    sync_cnt_d = SYNC_CW'(1);
                end
            end

            FR_SYNC: begin
                if (hs) begin
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_d   = FR_START;
                        tx_data_d = START_BYTE;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SYNC_CW'(1);
                        tx_data_d  = SYNC_BYTE;
                    end
                end
            end

            FR_START: begin
                if (hs) begin
                    state_d   = FR_DATA;
                    idx_d     = '0;
                    tx_data_d = rd_data;
                end
            end

            FR_DATA: begin
                if (hs) begin
                    if (idx_q == IDX_LAST) begin
                        state_d   = FR_TRAILER;
                        cont_d    = pending_q && enable;
                        tx_data_d = trailer_byte(cont_d, END_BYTE);
                    end else begin
                        idx_d     = idx_q + FRAME_AW'(1);
                        tx_data_d = rd_data;
                    end
                end
            end

            FR_TRAILER: begin
                if (hs) begin
                    frames_d = frames_q + 16'd1;
                    if (cont_q) begin
                        swap      = 1'b1;
                        state_d   = FR_START;
                        tx_data_d = START_BYTE;
                    end else begin
                        state_d    = FR_IDLE;
                        tx_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d    = FR_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // A swap consumes the back buffer, including a commit arriving in the
        // same cycle, so it takes priority over setting pending.
        if (swap) begin
            pending_d = 1'b0;
        end else if (frame_commit) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FR_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            frames_q   <= '0;
            idx_q      <= '0;
            sync_cnt_q <= '0;
            cont_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            pending_q  <= pending_d;
            frames_q   <= frames_d;
            idx_q      <= idx_d;
            sync_cnt_q <= sync_cnt_d;
            cont_q     <= cont_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = (state_q != FR_IDLE);
    assign frame_pending = pending_q;
    assign frames_sent   = frames_q;

endmodule

// File: tb/tb_led_cube_stream_framer.sv
// ---------------------------------------------------------------------------
// tb_led_cube_stream_framer
// Two framers share all inputs: dut0 with SYNC_COUNT=1/END_BYTE=00 and dut1
// with SYNC_COUNT=3/END_BYTE=C3. A monitor logs every accepted byte; the
// expected byte stream is built from frame images and the framing rules.
// ---------------------------------------------------------------------------
module tb_led_cube_stream_framer;

    localparam int MAXB = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, wr_en, frame_commit, tx_ready;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  txd   [2];
    logic        txv   [2];
    logic        bsy   [2];
    logic        pend  [2];
    logic [15:0] fsent [2];

    led_cube_stream_framer #(.SYNC_COUNT(1), .END_BYTE(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_commit(frame_commit),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
        .busy(bsy[0]), .frame_pending(pend[0]), .frames_sent(fsent[0])
    );

    led_cube_stream_framer #(.SYNC_COUNT(3), .END_BYTE(8'hC3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_commit(frame_commit),
        .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
        .busy(bsy[1]), .frame_pending(pend[1]), .frames_sent(fsent[1])
    );

    int         sc_of [2] = '{1, 3};
    logic [7:0] eb_of [2] = '{8'h00, 8'hC3};

    int total = 0;
    int bad   = 0;

    // Monitor state (written only by the monitor process).
    int         cyc = 0;
    int         stab_viol = 0;
    logic [7:0] got_b [2][MAXB];
    int         got_t [2][MAXB];
    int         got_n [2] = '{0, 0};
    bit         held  [2] = '{1'b0, 1'b0};
    logic [7:0] held_d[2];

    // Reference state (written only by the stimulus process).
    logic [7:0] exp_b [2][MAXB];
    int         exp_n [2];
    int         base  [2];
    logic [7:0] bb    [64];
    logic [7:0] slot  [2][64];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst_n !== 1'b1) begin
                held[k] = 1'b0;
            end else begin
                if (held[k] && (txv[k] !== 1'b1 || txd[k] !== held_d[k]))
                    stab_viol = stab_viol + 1;
                if (txv[k] === 1'b1 && tx_ready === 1'b1 && got_n[k] < MAXB) begin
                    got_b[k][got_n[k]] = txd[k];
                    got_t[k][got_n[k]] = cyc;
                    got_n[k] = got_n[k] + 1;
                end
                held[k]   = (txv[k] === 1'b1) && (tx_ready !== 1'b1);
                held_d[k] = txd[k];
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic exp_push(input int k, input logic [7:0] b);
        if (exp_n[k] < MAXB) begin
            exp_b[k][exp_n[k]] = b;
            exp_n[k] = exp_n[k] + 1;
        end
    endtask

    // One frame as seen on the link: sync prefix only when leaving idle,
    // trailer 0x30 when the next frame follows directly.
    task automatic model_frame(input int s, input bit from_idle, input bit cont);
        for (int k = 0; k < 2; k++) begin
            if (from_idle)
                for (int i = 0; i < sc_of[k]; i++) exp_push(k, 8'h30);
            exp_push(k, 8'h20);
            for (int i = 0; i < 64; i++) exp_push(k, slot[s][i]);
            exp_push(k, cont ? 8'h30 : eb_of[k]);
        end
    endtask

    task automatic start_capture();
        for (int k = 0; k < 2; k++) begin
            exp_n[k] = 0;
            base[k]  = got_n[k];
        end
    endtask

    function automatic int stream_diff(input int k);
        int n;
        n = got_n[k] - base[k];
        for (int i = 0; i < n && i < exp_n[k]; i++)
            if (got_b[k][base[k] + i] !== exp_b[k][i]) return i;
        if (n != exp_n[k]) return (n < exp_n[k]) ? n : exp_n[k];
        return -1;
    endfunction

    function automatic logic [7:0] got_at(input int k, input int i);
        if (base[k] + i < got_n[k]) return got_b[k][base[k] + i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(input int k, input int i);
        if (i < exp_n[k]) return exp_b[k][i];
        return 8'hxx;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // mode 0: data = address, mode 1: 0xA5 fill, otherwise random
    task automatic write_frame(input int mode);
        for (int a = 0; a < 64; a++) begin
            wr_en   = 1'b1;
            wr_addr = 6'(a);
            wr_data = (mode == 0) ? 8'(a) : (mode == 1) ? 8'hA5 : 8'($urandom);
            bb[a]   = wr_data;
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic commit(input int s);
        frame_commit = 1'b1;
        step();
        frame_commit = 1'b0;
        for (int i = 0; i < 64; i++) slot[s][i] = bb[i];
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((bsy[0] === 1'b1 || bsy[1] === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_idle_timeout: still busy after %0d cycles, need idle", name, n);
        end
    endtask

    task automatic wait_count(input int k, input int cnt, input string name);
        int n = 0;
        @(negedge clk);
        while (got_n[k] < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_count_timeout dut%0d: got %0d bytes, need %0d", name, k, got_n[k], cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (txv[k] !== 1'b0 || txd[k] !== 8'h00 || bsy[k] !== 1'b0 ||
                pend[k] !== 1'b0 || fsent[k] !== 16'd0) begin
                bad++;
                $display("FAIL reset dut%0d: valid=%b data=%02h busy=%b pend=%b sent=%0d, need 0 00 0 0 0",
                         k, txv[k], txd[k], bsy[k], pend[k], fsent[k]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        enable   = 1'b1;
        tx_ready = 1'b1;
        write_frame(0);
        start_capture();
        frame_commit = 1'b1;
        step();
        frame_commit = 1'b0;
        for (int i = 0; i < 64; i++) slot[0][i] = bb[i];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (pend[k] !== 1'b1 || txv[k] !== 1'b0) begin
                bad++;
                $display("FAIL latency_c1 dut%0d: pend=%b valid=%b, need 1 0", k, pend[k], txv[k]);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (txv[k] !== 1'b1 || txd[k] !== 8'h30) begin
                bad++;
                $display("FAIL latency_c2 dut%0d: valid=%b data=%02h, need 1 30", k, txv[k], txd[k]);
            end
        end
        wait_idle("single");
        model_frame(0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            int d;
            d = stream_diff(k);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL single_stream dut%0d byte %0d: got %02h need %02h (got %0d bytes, need %0d)",
                         k, d, got_at(k, d), exp_at(k, d), got_n[k] - base[k], exp_n[k]);
            end
            total++;
            if (fsent[k] !== 16'd1 || txv[k] !== 1'b0) begin
                bad++;
                $display("FAIL single_end dut%0d: sent=%0d valid=%b, need 1 0", k, fsent[k], txv[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int mark [2];
        do_reset();
        enable   = 1'b1;
        tx_ready = 1'b1;
        write_frame(2);
        start_capture();
        commit(0);
        wait_count(1, base[1] + 3 + 1 + 10, "b2b");
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        write_frame(1);
        commit(1);
        tx_ready = 1'b1;
        for (int k = 0; k < 2; k++) mark[k] = got_n[k];
        wait_idle("b2b");
        model_frame(0, 1'b1, 1'b1);
        model_frame(1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            int d;
            int n;
            d = stream_diff(k);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL b2b_stream dut%0d byte %0d: got %02h need %02h (got %0d bytes, need %0d)",
                         k, d, got_at(k, d), exp_at(k, d), got_n[k] - base[k], exp_n[k]);
            end
            n = got_n[k];
            total++;
            if (n <= mark[k] || got_t[k][n - 1] - got_t[k][mark[k]] != n - 1 - mark[k]) begin
                bad++;
                $display("FAIL b2b_bubble dut%0d: %0d cycles for %0d bytes, need %0d cycles",
                         k, (n > mark[k]) ? got_t[k][n - 1] - got_t[k][mark[k]] + 1 : 0,
                         n - mark[k], n - mark[k]);
            end
            total++;
            if (fsent[k] !== 16'd2 || pend[k] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_end dut%0d: sent=%0d pend=%b, need 2 0", k, fsent[k], pend[k]);
            end
        end
    endtask

    task automatic test_ready_random();
        int n = 0;
        do_reset();
        enable   = 1'b1;
        tx_ready = 1'b1;
        write_frame(2);
        start_capture();
        commit(0);
        while ((n < 3 || bsy[0] === 1'b1 || bsy[1] === 1'b1) && n < 4000) begin
            tx_ready = ($urandom_range(0, 99) < 55);
            step();
            n++;
        end
        tx_ready = 1'b1;
        total++;
        if (n >= 4000) begin
            bad++;
            $display("FAIL rnd_timeout: still busy after %0d cycles, need idle", n);
        end
        model_frame(0, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int d;
            d = stream_diff(k);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL rnd_stream dut%0d byte %0d: got %02h need %02h (got %0d bytes, need %0d)",
                         k, d, got_at(k, d), exp_at(k, d), got_n[k] - base[k], exp_n[k]);
            end
            total++;
            if (fsent[k] !== 16'd1) begin
                bad++;
                $display("FAIL rnd_sent dut%0d: sent=%0d, need 1", k, fsent[k]);
            end
        end
        total++;
        if (stab_viol != 0) begin
            bad++;
            $display("FAIL hold_stable: %0d changes while valid && !ready, need 0", stab_viol);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable   = 1'b1;
        tx_ready = 1'b1;
        write_frame(2);
        start_capture();
        commit(0);
        wait_count(1, base[1] + 3 + 1 + 10, "endrop");
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        write_frame(2);
        commit(1);
        enable   = 1'b0;
        tx_ready = 1'b1;
        wait_idle("endrop");
        model_frame(0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            int d;
            d = stream_diff(k);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL endrop_stream dut%0d byte %0d: got %02h need %02h (got %0d bytes, need %0d)",
                         k, d, got_at(k, d), exp_at(k, d), got_n[k] - base[k], exp_n[k]);
            end
            total++;
            if (pend[k] !== 1'b1 || fsent[k] !== 16'd1 || txv[k] !== 1'b0) begin
                bad++;
                $display("FAIL endrop_idle dut%0d: pend=%b sent=%0d valid=%b, need 1 1 0",
                         k, pend[k], fsent[k], txv[k]);
            end
        end
        repeat (5) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (txv[k] !== 1'b0 || bsy[k] !== 1'b0) begin
                bad++;
                $display("FAIL endrop_hold dut%0d: valid=%b busy=%b, need 0 0", k, txv[k], bsy[k]);
            end
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        step();
        wait_idle("reenable");
        model_frame(1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            int d;
            d = stream_diff(k);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL reenable_stream dut%0d byte %0d: got %02h need %02h (got %0d bytes, need %0d)",
                         k, d, got_at(k, d), exp_at(k, d), got_n[k] - base[k], exp_n[k]);
            end
            total++;
            if (fsent[k] !== 16'd2 || pend[k] !== 1'b0) begin
                bad++;
                $display("FAIL reenable_end dut%0d: sent=%0d pend=%b, need 2 0", k, fsent[k], pend[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        enable   = 1'b1;
        tx_ready = 1'b1;
        start_capture();
        commit(0);
        wait_count(0, base[0] + 2 + 5, "rstmid");
        @(posedge clk);
        #1;
        frame_commit = 1'b1;
        step();
        frame_commit = 1'b0;
        wait_count(0, base[0] + 2 + 30, "rstmid");
        for (int k = 0; k < 2; k++) begin
            total++;
            if (pend[k] !== 1'b1 || fsent[k] !== 16'd2 || bsy[k] !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_pre dut%0d: pend=%b sent=%0d busy=%b, need 1 2 1",
                         k, pend[k], fsent[k], bsy[k]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (txv[k] !== 1'b0 || txd[k] !== 8'h00 || bsy[k] !== 1'b0 ||
                pend[k] !== 1'b0 || fsent[k] !== 16'd0) begin
                bad++;
                $display("FAIL rstmid dut%0d: valid=%b data=%02h busy=%b pend=%b sent=%0d, need 0 00 0 0 0",
                         k, txv[k], txd[k], bsy[k], pend[k], fsent[k]);
            end
        end
        repeat (4) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (txv[k] !== 1'b0 || bsy[k] !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_stay dut%0d: valid=%b busy=%b, need 0 0", k, txv[k], bsy[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_commit_swap();
        do_reset();
        enable   = 1'b1;
        tx_ready = 1'b1;
        write_frame(2);
        start_capture();
        frame_commit = 1'b1;
        step();
        for (int i = 0; i < 64; i++) slot[0][i] = bb[i];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (pend[k] !== 1'b1 || txv[k] !== 1'b0) begin
                bad++;
                $display("FAIL swapc_c1 dut%0d: pend=%b valid=%b, need 1 0", k, pend[k], txv[k]);
            end
        end
        @(posedge clk);
        #1;
        frame_commit = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (pend[k] !== 1'b0 || txv[k] !== 1'b1 || txd[k] !== 8'h30) begin
                bad++;
                $display("FAIL swapc_c2 dut%0d: pend=%b valid=%b data=%02h, need 0 1 30",
                         k, pend[k], txv[k], txd[k]);
            end
        end
        wait_idle("swapc");
        model_frame(0, 1'b1, 1'b0);
        repeat (5) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int d;
            d = stream_diff(k);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL swapc_stream dut%0d byte %0d: got %02h need %02h (got %0d bytes, need %0d)",
                         k, d, got_at(k, d), exp_at(k, d), got_n[k] - base[k], exp_n[k]);
            end
            total++;
            if (fsent[k] !== 16'd1 || pend[k] !== 1'b0 || txv[k] !== 1'b0) begin
                bad++;
                $display("FAIL swapc_end dut%0d: sent=%0d pend=%b valid=%b, need 1 0 0",
                         k, fsent[k], pend[k], txv[k]);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        frame_commit = 1'b0;
        tx_ready     = 1'b1;
        for (int i = 0; i < 64; i++) bb[i] = '0;

        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ready_random();
        test_enable_drop();
        test_reset_mid();
        test_commit_swap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/led_cube_stream_framer.md
# led_cube_stream_framer

Transmit-side framer for the LED cube streaming protocol (mode 3). It holds one 64-byte cube frame in a ping-pong buffer written by the producer, then serialises it as a byte stream: SYNC_COUNT sync bytes 0x30, start byte 0x20, 64 data bytes, and a trailer byte. The trailer is 0x30 if another frame follows back-to-back, otherwise END_BYTE. It sits between the frame producer (pattern generator or host bridge) and the byte link feeding the cube's stream receiver.

## Interface
- SYNC_COUNT, default 1: number of 0x30 bytes emitted before 0x20 when starting from idle; legal range 1..15.
- END_BYTE, default 8'h00: trailer byte when no frame follows; must not be 8'h30.
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  streaming permitted (high while cube mode is 4'h3).
- wr_en  in  1  write one byte into the back buffer.
- wr_addr  in  6  byte index 0..63 in back buffer.
- wr_data  in  8  byte to write.
- frame_commit  in  1  one-cycle pulse: back buffer is a complete frame.
- tx_data  out  8  stream byte, registered.
- tx_valid  out  1  tx_data valid, registered.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- busy  out  1  high in any state except IDLE.
- frame_pending  out  1  committed frame waiting in back buffer.
- frames_sent  out  16  count of completed frames (trailer accepted), wraps 0xFFFF→0.

## Operation
- States: IDLE, SYNC, START, DATA, TRAILER. State names the byte currently presented on tx_data.
- Handshake hs = tx_valid && tx_ready. tx_data and tx_valid stay stable until hs. Transitions out of SYNC, START, DATA and TRAILER happen only on hs.
- IDLE: tx_valid=0. If pending && enable, then swap buffers, clear pending, go to SYNC, tx_data=0x30, sync_cnt=1, tx_valid=1.
- SYNC, on hs: if sync_cnt==SYNC_COUNT, go to START with tx_data=0x20. Otherwise sync_cnt++ and tx_data=0x30.
- START, on hs: go to DATA, idx=0, tx_data=front[0].
- DATA, on hs: if idx==63, go to TRAILER. Latch cont = pending && enable. Set tx_data = cont ? 0x30 : END_BYTE. Otherwise idx++ and tx_data=front[idx+1].
- TRAILER, on hs: frames_sent++. If cont, swap, clear pending, go to START with tx_data=0x20 (no extra sync bytes). Otherwise go to IDLE with tx_valid=0.
- Buffer writes always target the back buffer, in any state. The front buffer is read-only while busy.
- frame_commit sets pending. Writing or committing while pending is already set overwrites the waiting frame; the latest data wins.
- frame_commit in the same cycle as a swap: the swap claims those contents and pending ends at 0.
- enable dropping mid-frame does not abort the frame. It only forces the trailer to END_BYTE if it drops before the trailer is chosen. The frame then returns to IDLE.
- Sequence guarantees the receiver never sees 0x20 without a preceding 0x30, and data is exactly 64 bytes.

## Timing
- Reset values: state IDLE, tx_valid=0, tx_data=8'h00, busy=0, frame_pending=0, frames_sent=0, idx=0, sync_cnt=0, front select=0.
- Reset asserted mid-frame: all of the above on the next edge. Buffer contents are undefined; no reset is needed on the array.
- Latency: commit in cycle c with state IDLE and enable=1 gives pending=1 in c+1 and tx_valid=1 with 0x30 in c+2.
- With tx_ready held high, one byte per cycle. A back-to-back frame costs 65 bytes (0x20 + 64 data) plus its trailer.
- Zero-bubble: no idle cycle between any bytes of a frame, or between a 0x30 trailer and the next 0x20.
- wr_en and rd are the same cycle: the write lands in the back buffer and never affects the byte being sent.

## Structure
- Package led_cube_stream_pkg: SYNC_BYTE=8'h30, START_BYTE=8'h20, FRAME_BYTES=64, FRAME_AW=6, framer state enum. These are shared with the receive side.
- Sub-module led_cube_frame_pingpong: two 64×8 arrays, back-write port, combinational front-read port, swap input, front select flop.
- Top: FSM, counters, output registers.

## Test plan
- Write bytes 0..63 = addr, commit, tx_ready=1, SYNC_COUNT=1 -> stream 30 20 00 01 … 3F 00, then tx_valid=0; frames_sent=1.
- Commit a second frame (0xA5 fill) during DATA of the first -> trailer 30, then 20 A5×64 00 with no bubble; frames_sent=2.
- tx_ready toggled pseudo-randomly -> byte sequence identical to the ready=1 case; tx_data never changes while valid && !ready.
- enable dropped at data byte 10 with a frame pending -> frame completes, trailer END_BYTE, IDLE, pending stays 1; re-raising enable starts 30 20.
- rst_n low for one cycle at data byte 30 -> next cycle tx_valid=0, busy=0, frame_pending=0, frames_sent=0.
- SYNC_COUNT=3, commit and frame_commit coincident with swap -> 30 30 30 20 …; frame_pending reads 0 after the swap.
